rr_mux_arbiter: RTL and testbench

//  Round-robin arbiter/scheduler that shares one 8:1 single-bit mux among 8 requesters.

---
 rtl/rr_mux_arbiter_pkg.sv | 16 +
 rtl/rr_mux_arbiter_rr_pick.sv | 30 +++
 rtl/rr_mux_arbiter.sv | 116 +++++++++++
 tb/tb_rr_mux_arbiter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/rr_mux_arbiter_pkg.sv
// rtl/rr_mux_arbiter_pkg.sv - shared types and constants for the round-robin mux arbiter
package rr_mux_arbiter_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_rr_pick.sv
// rtl/rr_mux_arbiter_rr_pick.sv - rotate-priority search starting just after ptr
module rr_pick
  import rr_mux_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [N_REQ-1:0] excl,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [N_REQ-1:0] cand;
  logic [SEL_W-1:0] pos;

  // Scan farthest-to-nearest so the nearest candidate after ptr is written last and wins.
  always_comb begin
    cand  = req & ~excl;
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      pos = ptr + SEL_W'(k);
      if (cand[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin arbiter driving the select of a shared 8:1 bit mux
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic [N_REQ-1:0] reqIn,
  input  logic [N_REQ-1:0] dataIn,
  output logic [N_REQ-1:0] grantOut,
  output logic             grantValid,
  output logic [SEL_W-1:0] selectLine,
  output logic             dataOut
);

  localparam bit             PREEMPT_EN = (HOLD_MAX != 0);
  localparam logic [CNT_W-1:0] HOLD_LIM = (HOLD_MAX == 0) ? {CNT_W{1'b1}} : CNT_W'(HOLD_MAX - 1);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             data_q, data_d;
  logic [SEL_W-1:0] last_ptr_q, last_ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [N_REQ-1:0] pick_excl;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;

  rr_pick u_pick (
    .req   (reqIn),
    .ptr   (last_ptr_q),
    .excl  (pick_excl),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    last_ptr_d = last_ptr_q;
    hold_cnt_d = hold_cnt_q;
    pick_excl  = (state_q == GRANT) ? grant_q : '0;

    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (pick_found) begin
          grant_d    = idx_to_onehot(pick_idx);
          sel_d      = pick_idx;
          last_ptr_d = pick_idx;
          hold_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        // While granted, sel_q is the holder's index and last_ptr_q equals it.
        if (!reqIn[sel_q]) begin
          hold_cnt_d = '0;
          if (pick_found) begin
            grant_d    = idx_to_onehot(pick_idx);
            sel_d      = pick_idx;
            last_ptr_d = pick_idx;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end else if (PREEMPT_EN && (hold_cnt_q == HOLD_LIM) && pick_found) begin
          grant_d    = idx_to_onehot(pick_idx);
          sel_d      = pick_idx;
          last_ptr_d = pick_idx;
          hold_cnt_d = '0;
        end else if (hold_cnt_q != HOLD_LIM) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase

    valid_d = |grant_d;
    data_d  = valid_q ? dataIn[sel_q] : 1'b0;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      valid_q    <= 1'b0;
      sel_q      <= '0;
      data_q     <= 1'b0;
      last_ptr_q <= SEL_W'(N_REQ - 1);
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      valid_q    <= valid_d;
      sel_q      <= sel_d;
      data_q     <= data_d;
      last_ptr_q <= last_ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign grantOut   = grant_q;
  assign grantValid = valid_q;
  assign selectLine = sel_q;
  assign dataOut    = data_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - directed self-checking bench for rr_mux_arbiter
module tb_rr_mux_arbiter;

  logic       clk = 1'b0;
  logic       rstN;
  logic [7:0] reqIn;
  logic [7:0] dataIn;
  logic [7:0] grantOut;
  logic       grantValid;
  logic [2:0] selectLine;
  logic       dataOut;

  int checks = 0;
  int errors = 0;

  rr_mux_arbiter #(.HOLD_MAX(4), .CNT_W(5)) dut (
    .clk        (clk),
    .rstN       (rstN),
    .reqIn      (reqIn),
    .dataIn     (dataIn),
    .grantOut   (grantOut),
    .grantValid (grantValid),
    .selectLine (selectLine),
    .dataOut    (dataOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstN   = 1'b0;
    reqIn  = 8'h00;
    dataIn = 8'h00;
    tick();
    tick();
    rstN = 1'b1;
  endtask

  task automatic check_grant(input string tag, input int idx);
    check({tag, "_grant"}, 32'(grantOut), 32'(8'h01 << idx));
    check({tag, "_sel"}, 32'(selectLine), 32'(idx));
    check({tag, "_valid"}, 32'(grantValid), 32'd1);
  endtask

  initial begin
    // 1: reset state and idle with no requests
    do_reset();
    check("rst_grant", 32'(grantOut), 32'h0);
    check("rst_valid", 32'(grantValid), 32'h0);
    check("rst_sel", 32'(selectLine), 32'h0);
    check("rst_data", 32'(dataOut), 32'h0);
    check("rst_hold", 32'(dut.hold_cnt_q), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_grant", 32'(grantOut), 32'h0);
      check("idle_valid", 32'(grantValid), 32'h0);
      check("idle_data", 32'(dataOut), 32'h0);
    end

    // 2: single request, data follows one cycle behind the grant
    reqIn  = 8'h01;
    dataIn = 8'h01;
    tick();
    check_grant("single", 0);
    check("single_data_lag", 32'(dataOut), 32'h0);
    tick();
    check("single_data", 32'(dataOut), 32'h1);
    reqIn = 8'h00;
    tick();
    check("release_idle_grant", 32'(grantOut), 32'h0);
    check("release_idle_valid", 32'(grantValid), 32'h0);
    check("release_sel_hold", 32'(selectLine), 32'h0);
    check("release_data_last", 32'(dataOut), 32'h1);
    tick();
    check("release_data_zero", 32'(dataOut), 32'h0);

    // 3: all requesting, each holder drops after two cycles; order wraps with no gaps
    do_reset();
    reqIn = 8'hFF;
    tick();
    for (int k = 0; k < 9; k++) begin
      check_grant("rr_first", k % 8);
      tick();
      check_grant("rr_second", k % 8);
      reqIn = 8'hFF ^ (8'h01 << (k % 8));
      tick();
      reqIn = 8'hFF;
    end
    check_grant("rr_after_wrap", 1);

    // 4: two holders preempt each other every HOLD_MAX cycles
    do_reset();
    reqIn = 8'h81;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_grant("preempt", ((i / 4) % 2 == 0) ? 0 : 7);
      check("preempt_hold", 32'(dut.hold_cnt_q), 32'(i % 4));
    end

    // 5: lone holder is never preempted, hold counter saturates
    do_reset();
    reqIn = 8'h04;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_grant("lone", 2);
      check("lone_hold", 32'(dut.hold_cnt_q), 32'((i < 3) ? i : 3));
    end

    // 6: asynchronous reset mid-grant, then first search restarts at requester 0
    do_reset();
    dataIn = 8'hFF;
    reqIn  = 8'h10;
    tick();
    check_grant("pre_rst", 4);
    tick();
    check("pre_rst_data", 32'(dataOut), 32'h1);
    #3;
    rstN = 1'b0;
    #1;
    check("async_grant", 32'(grantOut), 32'h0);
    check("async_valid", 32'(grantValid), 32'h0);
    check("async_sel", 32'(selectLine), 32'h0);
    check("async_data", 32'(dataOut), 32'h0);
    tick();
    rstN  = 1'b1;
    reqIn = 8'h30;
    tick();
    check_grant("post_rst", 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
